// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front end: PC source select,
// trap cause codes, PC generator state and the default trap vector.
package core_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_TRAP     = 2'b01,
    CAUSE_MISALIGN = 2'b10,
    CAUSE_DOUBLE   = 2'b11
  } cause_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_HANDLER = 2'b01,
    ST_HALT    = 2'b10
  } state_t;

  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0100;

  // Instruction targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Control/status bundle between the control unit and the PC generator.
interface pc_gen_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 32
) ();

  logic                     stall;
  logic [1:0]               PCsrc;
  logic [DATA_WIDTH-1:0]    ImmOp;
  logic [DATA_WIDTH-1:0]    rs1_val;
  logic                     trap_req;
  logic                     mret;
  logic [ADDRESS_WIDTH-1:0] PC;
  logic [ADDRESS_WIDTH-1:0] PC_plus4;
  logic [ADDRESS_WIDTH-1:0] epc;
  core_pkg::cause_t         cause;
  logic                     halted;
  logic [COUNT_WIDTH-1:0]   instret;

  modport master (
    output stall, PCsrc, ImmOp, rs1_val, trap_req, mret,
    input  PC, PC_plus4, epc, cause, halted, instret
  );

  modport slave (
    input  stall, PCsrc, ImmOp, rs1_val, trap_req, mret,
    output PC, PC_plus4, epc, cause, halted, instret
  );

endinterface

// File: rtl/pc_target_sel.sv
// Next-PC target mux with misalignment detect. Arithmetic is done at
// operand width and the low address bits are taken, so targets wrap.
module pc_target_sel
  import core_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  pc_src_t                  src,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [DATA_WIDTH-1:0]    rs1_val,
  output logic [ADDRESS_WIDTH-1:0] target,
  output logic                     misaligned
);

  logic [DATA_WIDTH-1:0] pc_ext;
  logic [DATA_WIDTH-1:0] tgt;
  logic                  redirect;

  assign pc_ext = DATA_WIDTH'(pc);

  // Pick the target; the reserved encoding falls through to sequential.
  always_comb begin
    tgt      = pc_ext + DATA_WIDTH'(4);
    redirect = 1'b0;
    case (src)
      PC_BRANCH: begin
        tgt      = pc_ext + imm;
        redirect = 1'b1;
      end
      PC_JALR: begin
        tgt      = rs1_val + imm;
        tgt[0]   = 1'b0;
        redirect = 1'b1;
      end
      default: ;
    endcase
  end

  assign target     = tgt[ADDRESS_WIDTH-1:0];
  assign misaligned = redirect && is_misaligned(tgt[1:0]);

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: owns the PC, handles stall, traps,
// exception return, halt on double fault and the retired counter.
module pc_gen
  import core_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [31:0]              TRAP_VECTOR   = DEFAULT_TRAP_VECTOR,
  parameter int                       COUNT_WIDTH   = 32
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] TRAP_PC = ADDRESS_WIDTH'(TRAP_VECTOR);

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] epc_q, epc_d;
  cause_t                   cause_q, cause_d;
  logic [COUNT_WIDTH-1:0]   instret_q;
  logic                     retire;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     misaligned;
  logic                     fault;

  pc_target_sel #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_sel (
    .pc        (pc_q),
    .src       (pc_src_t'(bus.PCsrc)),
    .imm       (bus.ImmOp),
    .rs1_val   (bus.rs1_val),
    .target    (target),
    .misaligned(misaligned)
  );

  // A misaligned target is a fault even when the cycle is stalled.
  assign fault = bus.trap_req | misaligned;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state: fault enters the handler or halts from inside it; an
  // unstalled mret leaves the handler. HALT only exits via reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (fault) state_d = ST_HANDLER;
      ST_HANDLER: begin
        if (fault)                     state_d = ST_HALT;
        else if (!bus.stall && bus.mret) state_d = ST_RUN;
      end
      default:    state_d = state_q;
    endcase
  end

  // Datapath next values and retire strobe for the current state.
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (fault) begin
          pc_d    = TRAP_PC;
          epc_d   = pc_q;
          cause_d = bus.trap_req ? CAUSE_TRAP : CAUSE_MISALIGN;
        end else if (!bus.stall) begin
          pc_d   = target;
          retire = 1'b1;
        end
      end
      ST_HANDLER: begin
        if (fault) begin
          cause_d = CAUSE_DOUBLE;
        end else if (!bus.stall) begin
          retire = 1'b1;
          if (bus.mret) begin
            pc_d    = epc_q;
            cause_d = CAUSE_NONE;
          end else begin
            pc_d = target;
          end
        end
      end
      default: ;
    endcase
  end

  // Architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      cause_q   <= CAUSE_NONE;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
      instret_q <= instret_q + {{(COUNT_WIDTH-1){1'b0}}, retire};
    end
  end

  assign bus.PC       = pc_q;
  assign bus.PC_plus4 = pc_q + ADDRESS_WIDTH'(4);
  assign bus.epc      = epc_q;
  assign bus.cause    = cause_q;
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: a 32-bit and an 8-bit-address instance, each shadowed
// by a behavioural model and compared every cycle, plus literal checks.
module tb_pc_gen;

  logic clk;
  logic rst;
  logic rst8;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 0;
  int   hc;

  pc_gen_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(32)) bus ();
  pc_gen_if #(.ADDRESS_WIDTH(8),  .DATA_WIDTH(32), .COUNT_WIDTH(32)) bus8 ();

  pc_gen #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0),
           .TRAP_VECTOR(32'h100), .COUNT_WIDTH(32))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  pc_gen #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .RESET_PC(8'hF0),
           .TRAP_VECTOR(32'h100), .COUNT_WIDTH(32))
    u_dut8 (.clk(clk), .rst(rst8), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  typedef struct {
    longint unsigned pc;
    longint unsigned epc;
    longint unsigned instret;
    int              cause;
    int              st;     // 0 run, 1 in handler, 2 halted
  } mdl_t;

  mdl_t m32, m8;

  function automatic mdl_t mreset(longint unsigned pc0);
    mdl_t r;
    r.pc = pc0; r.epc = 0; r.instret = 0; r.cause = 0; r.st = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int aw, bit stall, int src,
                                 longint unsigned imm, longint unsigned rs1,
                                 bit trap, bit mret);
    longint unsigned amask = (64'd1 << aw) - 1;
    longint unsigned dmask = 64'hFFFF_FFFF;
    longint unsigned tgt;
    bit redir = 0;
    bit misal;
    mdl_t n = m;
    if (src == 1) begin
      tgt = (m.pc + imm) & dmask; redir = 1;
    end else if (src == 2) begin
      tgt = ((rs1 + imm) & dmask) & ~64'd1; redir = 1;
    end else begin
      tgt = (m.pc + 4) & dmask;
    end
    misal = redir && (tgt % 4 != 0);
    tgt   = tgt & amask;
    if (m.st == 2) return n;
    if (trap || misal) begin
      if (m.st == 0) begin
        n.epc = m.pc; n.pc = 64'h100 & amask;
        n.cause = trap ? 1 : 2; n.st = 1;
      end else begin
        n.cause = 3; n.st = 2;
      end
      return n;
    end
    if (stall) return n;
    if (mret && m.st == 1) begin
      n.pc = m.epc; n.st = 0; n.cause = 0;
    end else begin
      n.pc = tgt;
    end
    n.instret = (m.instret + 1) & dmask;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m32 <= mreset(64'h0);
    else     m32 <= mstep(m32, 32, bus.stall, int'(bus.PCsrc), bus.ImmOp,
                          bus.rs1_val, bus.trap_req, bus.mret);
  end

  always @(posedge clk or posedge rst8) begin
    if (rst8) m8 <= mreset(64'hF0);
    else      m8 <= mstep(m8, 8, bus8.stall, int'(bus8.PCsrc), bus8.ImmOp,
                          bus8.rs1_val, bus8.trap_req, bus8.mret);
  end

  task automatic chk(string n, longint unsigned a, longint unsigned e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Every-cycle comparison against the models.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pc",      bus.PC,       m32.pc);
      chk("pc4",     bus.PC_plus4, (m32.pc + 4) & 64'hFFFF_FFFF);
      chk("epc",     bus.epc,      m32.epc);
      chk("cause",   bus.cause,    m32.cause);
      chk("halted",  bus.halted,   m32.st == 2);
      chk("instret", bus.instret,  m32.instret);
      chk("pc_8",      bus8.PC,       m8.pc);
      chk("pc4_8",     bus8.PC_plus4, (m8.pc + 4) & 64'hFF);
      chk("epc_8",     bus8.epc,      m8.epc);
      chk("cause_8",   bus8.cause,    m8.cause);
      chk("halted_8",  bus8.halted,   m8.st == 2);
      chk("instret_8", bus8.instret,  m8.instret);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(bit s, logic [1:0] src, logic [31:0] imm,
                     logic [31:0] rs1, bit t, bit mr);
    bus.stall = s; bus.PCsrc = src; bus.ImmOp = imm;
    bus.rs1_val = rs1; bus.trap_req = t; bus.mret = mr;
  endtask

  task automatic drv8(bit s, logic [1:0] src, logic [31:0] imm,
                      logic [31:0] rs1, bit t, bit mr);
    bus8.stall = s; bus8.PCsrc = src; bus8.ImmOp = imm;
    bus8.rs1_val = rs1; bus8.trap_req = t; bus8.mret = mr;
  endtask

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    if ($urandom_range(0, 1) == 1) v = 32'($urandom_range(0, 128)) - 32'd64;
    else                           v = $urandom;
    if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  task automatic rnd_drv();
    drv($urandom_range(0, 99) < 15, 2'($urandom_range(0, 3)), rnd_opnd(),
        rnd_opnd(), $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 25);
  endtask

  task automatic rnd_drv8();
    drv8($urandom_range(0, 99) < 15, 2'($urandom_range(0, 3)), rnd_opnd(),
         rnd_opnd(), $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 25);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; rst8 = 1'b1;
    drv(0, 2'b00, 0, 0, 0, 0);
    drv8(0, 2'b00, 0, 0, 0, 0);
    #12;
    cmp_en = 1;
    chk("rst_pc",      bus.PC, 0);
    chk("rst_epc",     bus.epc, 0);
    chk("rst_cause",   bus.cause, 0);
    chk("rst_halted",  bus.halted, 0);
    chk("rst_instret", bus.instret, 0);
    @(negedge clk) rst = 1'b0;

    repeat (3) cyc();
    chk("seq3_pc", bus.PC, 32'hC);
    chk("seq3_instret", bus.instret, 3);
    cyc();
    chk("seq4_pc", bus.PC, 32'h10);

    drv(0, 2'b01, 32'hFFFF_FFF8, 0, 0, 0); cyc();
    chk("br_back_pc", bus.PC, 32'h08);
    drv(0, 2'b00, 0, 0, 0, 0); cyc(); cyc();
    chk("seq_to_10", bus.PC, 32'h10);
    drv(0, 2'b01, 32'h6, 0, 0, 0); cyc();
    chk("mis_pc",      bus.PC, 32'h100);
    chk("mis_epc",     bus.epc, 32'h10);
    chk("mis_cause",   bus.cause, 2);
    chk("mis_instret", bus.instret, 7);
    drv(0, 2'b00, 0, 0, 0, 1); cyc();
    chk("mret1_pc",    bus.PC, 32'h10);
    chk("mret1_cause", bus.cause, 0);
    chk("mret1_instret", bus.instret, 8);

    drv(0, 2'b10, 32'h0, 32'h201, 0, 0); cyc();
    chk("jalr_pc",    bus.PC, 32'h200);
    chk("jalr_cause", bus.cause, 0);
    drv(0, 2'b10, 32'h0, 32'h40, 0, 0); cyc();
    chk("jalr40_pc", bus.PC, 32'h40);

    drv(1, 2'b00, 0, 0, 1, 0); cyc();
    chk("trap_pc",    bus.PC, 32'h100);
    chk("trap_epc",   bus.epc, 32'h40);
    chk("trap_cause", bus.cause, 1);
    drv(0, 2'b00, 0, 0, 0, 1); cyc();
    chk("mret2_pc",    bus.PC, 32'h40);
    chk("mret2_cause", bus.cause, 0);

    drv(0, 2'b00, 0, 0, 1, 0); cyc();
    drv(0, 2'b00, 0, 0, 1, 0); cyc();
    chk("dbl_halted", bus.halted, 1);
    chk("dbl_cause",  bus.cause, 3);
    chk("dbl_pc",     bus.PC, 32'h100);
    for (int i = 0; i < 10; i++) begin
      rnd_drv(); cyc();
      chk("halt_pc", bus.PC, 32'h100);
      chk("halt_hi", bus.halted, 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_pc",      bus.PC, 0);
    chk("arst_halted",  bus.halted, 0);
    chk("arst_cause",   bus.cause, 0);
    chk("arst_instret", bus.instret, 0);
    drv(0, 2'b00, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    hc = 0;
    for (int i = 0; i < 3000; i++) begin
      rnd_drv(); cyc();
      if (bus.halted) begin
        hc++;
        if (hc > 3) begin
          #2 rst = 1'b1;
          #1 rst = 1'b0;
          hc = 0;
        end
      end
    end

    // Narrow-address instance: wrap at the top of the address space.
    drv(0, 2'b00, 0, 0, 0, 0);
    @(negedge clk) rst8 = 1'b0;
    #1;
    chk("r8_pc", bus8.PC, 8'hF0);
    repeat (3) cyc();
    chk("w8_pc_fc", bus8.PC, 8'hFC);
    chk("w8_pc4",   bus8.PC_plus4, 8'h00);
    cyc();
    chk("w8_wrap",    bus8.PC, 8'h00);
    chk("w8_instret", bus8.instret, 4);
    drv8(1, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("st8_pc",      bus8.PC, 8'h00);
      chk("st8_instret", bus8.instret, 4);
    end

    hc = 0;
    for (int i = 0; i < 1000; i++) begin
      rnd_drv8(); cyc();
      if (bus8.halted) begin
        hc++;
        if (hc > 3) begin
          #2 rst8 = 1'b1;
          #1 rst8 = 1'b0;
          hc = 0;
        end
      end
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised next-generation program counter for the single-cycle RV32I core. It owns the PC register and selects the next PC from these sources:
- sequential
- branch (PC+ImmOp)
- jump-register (rs1+ImmOp)
- trap vector
- exception return

It adds stall hold, misaligned-target detection, exception-PC capture, a handler/halt state machine and a retired-instruction counter. It sits at the head of fetch, drives the instruction-memory address, and takes control inputs from the control unit and ALU.

Parameters:
ADDRESS_WIDTH, 32, width of PC and instruction address
DATA_WIDTH, 32, width of ImmOp / rs1 operands
RESET_PC, 0, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, handler entry address (truncated to ADDRESS_WIDTH)
COUNT_WIDTH, 32, width of retired-instruction counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC this cycle
PCsrc  in  2  00 sequential, 01 branch PC+ImmOp, 10 jalr rs1+ImmOp, 11 reserved (treated as 00)
ImmOp  in  DATA_WIDTH  sign-extended immediate
rs1_val  in  DATA_WIDTH  register operand for jalr
trap_req  in  1  external/illegal-instruction trap request
mret  in  1  return from handler
PC  out  ADDRESS_WIDTH  current fetch address
PC_plus4  out  ADDRESS_WIDTH  PC+4 (link value), combinational from PC
epc  out  ADDRESS_WIDTH  captured faulting PC
cause  out  2  00 none, 01 trap_req, 10 misaligned target, 11 double fault
halted  out  1  high in HALT state
instret  out  COUNT_WIDTH  count of cycles that advanced PC while in RUN/HANDLER

Behaviour:
- Reset (async, any time, including mid-handler):
  - PC=RESET_PC, epc=0, cause=00, instret=0, state=RUN, halted=0.
- All target arithmetic is done in DATA_WIDTH, modulo 2^DATA_WIDTH; the low ADDRESS_WIDTH bits are taken. PC+4 wraps silently (max address + 4 -> 0).
- jalr target has bit 0 cleared before the alignment check.
- Misaligned: a selected target (PCsrc 01/10) with bits[1:0] != 00.
- States RUN, HANDLER, HALT. Per rising edge, priority is highest first:
  1. HALT: PC, epc, cause and instret all hold. Only rst exits.
  2. trap_req or misaligned target, state RUN: PC<=TRAP_VECTOR, epc<=PC, cause<=01 (trap_req) or 10 (misaligned; trap_req wins if both), state<=HANDLER. This overrides stall. instret does not increment.
  3. trap_req or misaligned target, state HANDLER: cause<=11, state<=HALT, PC holds.
  4. stall: PC holds, no increment.
  5. mret, state HANDLER: PC<=epc, state<=RUN, cause<=00, instret+1. mret in RUN is ignored and the PCsrc path applies.
  6. Otherwise: PC<=selected target per PCsrc, instret+1.
- Latency: a redirect selected in cycle N is visible on PC after edge N.
- instret wraps at 2^COUNT_WIDTH.
- stall with mret: stall wins; mret must be reasserted.

Decomposition:
- Shared package core_pkg holds:
  - pc_src_t enum (PC_SEQ, PC_BRANCH, PC_JALR)
  - cause_t enum
  - state enum
  - default TRAP_VECTOR constant
- One sub-module, pc_target_sel: combinational target mux plus misalign detect, reused by the future branch predictor.

Test Plan:
- Reset release, no stall, PCsrc=00 for 3 cycles -> PC 0,4,8,12; instret=3.
- PC=0x10, PCsrc=01, ImmOp=-8 -> PC=0x08; ImmOp=6 -> PC=0x100, epc=0x10, cause=10, state HANDLER.
- PCsrc=10, rs1_val=0x201, ImmOp=0 -> PC=0x200 (bit0 cleared), no trap.
- trap_req at PC=0x40 with stall=1 -> PC=0x100, epc=0x40, cause=01; then mret -> PC=0x40, cause=00.
- Second trap_req while in HANDLER -> halted=1, cause=11, PC frozen for 10 cycles; async rst mid-cycle -> PC=RESET_PC immediately, halted=0.
- ADDRESS_WIDTH=8, PC=0xFC, PCsrc=00 -> PC=0x00 (wrap); stall held 5 cycles -> PC and instret unchanged.
